// File: rtl/ble_auth_pkg.sv
// Shared types and command codes for the BLE authentication stage.
package ble_auth_pkg;

  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  typedef enum logic [1:0] {ARM, IDLE, RECV} rx_state_t;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/ble_auth_if.sv
// Pin bundle between the BLE UART / Digital_core side and ble_auth.
interface ble_auth_if;

  logic RX;
  logic rider_off;
  logic pwr_up;
  logic rx_err;

  modport master (output RX, rider_off, input pwr_up, rx_err);
  modport slave  (input RX, rider_off, output pwr_up, rx_err);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with RX synchroniser and a post-reset ARM phase that
// waits for a full bit-time of idle line before accepting a start bit.
module uart_rx
  import ble_auth_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_err
);

  localparam int unsigned CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic            rx_meta;
  logic            rx_s;
  rx_state_t       st;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [8:0]      shift;

  assign rx_data = shift[7:0];

  // Two-flop synchroniser, preset high so reset looks like an idle line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ARM;
      baud_cnt <= FULL;
      bit_cnt  <= 4'd0;
      shift    <= 9'd0;
      rx_rdy   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      rx_err <= 1'b0;
      case (st)
        ARM: begin
          // Any low cycle restarts the idle-line qualification window
          if (!rx_s)                 baud_cnt <= FULL;
          else if (baud_cnt == ONE)  st       <= IDLE;
          else                       baud_cnt <= baud_cnt - ONE;
        end
        IDLE: begin
          if (!rx_s) begin
            st       <= RECV;
            baud_cnt <= HALF;
            bit_cnt  <= 4'd0;
          end
        end
        RECV: begin
          if (baud_cnt == ONE) begin
            baud_cnt <= FULL;
            bit_cnt  <= bit_cnt + 4'd1;
            shift    <= {rx_s, shift[8:1]};
            if (bit_cnt == 4'd0 && rx_s) begin
              st <= IDLE;
            end else if (bit_cnt == 4'd9) begin
              st <= IDLE;
              if (rx_s) rx_rdy <= 1'b1;
              else      rx_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - ONE;
          end
        end
        default: st <= ARM;
      endcase
    end
  end

endmodule

// File: rtl/ble_auth.sv
// Authentication stage: decodes 'g'/'s' commands from the BLE UART into pwr_up,
// holding power on while a rider is still standing on the platform.
module ble_auth
  import ble_auth_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic         clk,
  input  logic         rst_n,
  ble_auth_if.slave    bus
);

  logic [7:0]  rx_data;
  logic        rx_rdy;
  auth_state_t state;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (bus.RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_err  (bus.rx_err)
  );

  // pwr_up is registered alongside state so it always equals (state != OFF)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      bus.pwr_up <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (rx_rdy && rx_data == CMD_GO) begin
            state      <= PWR1;
            bus.pwr_up <= 1'b1;
          end
        end
        PWR1: begin
          if (rx_rdy && rx_data == CMD_STOP) begin
            state      <= bus.rider_off ? OFF : PWR2;
            bus.pwr_up <= !bus.rider_off;
          end
        end
        PWR2: begin
          // A fresh 'g' overrides a simultaneous rider_off
          if (rx_rdy && rx_data == CMD_GO) begin
            state      <= PWR1;
            bus.pwr_up <= 1'b1;
          end else if (bus.rider_off) begin
            state      <= OFF;
            bus.pwr_up <= 1'b0;
          end
        end
        default: begin
          state      <= OFF;
          bus.pwr_up <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_auth.sv
// Scoreboard bench for ble_auth: directed UART frames, expected receive events
// queued by the stimulus and checked by an independent monitor.
module tb_ble_auth;

  localparam int unsigned BAUD = 16;

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic       pwr_before;
    logic       pwr_after;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  ble_auth_if bus ();

  ble_auth #(.BAUD_DIV(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic err, input logic [7:0] d, input logic pb, input logic pa);
    exp_t e;
    e.err = err; e.data = d; e.pwr_before = pb; e.pwr_after = pa;
    exp_q.push_back(e);
  endtask

  // Frame: start, 8 data LSB first, stop; called and returns on a negedge
  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.RX = f[i];
      repeat (BAUD) @(negedge clk);
    end
    bus.RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rdy(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!dut.u_rx.rx_rdy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait", 32'(dut.u_rx.rx_rdy), 32'd1);
  endtask

  task automatic idle_line(input logic v, input int n);
    bus.RX = v;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every receive event must match the head of the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (dut.u_rx.rx_rdy || bus.rx_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, bus.rx_err, dut.u_rx.rx_rdy}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_err", 32'(bus.rx_err), 32'(e.err));
          check("rx_rdy", 32'(dut.u_rx.rx_rdy), 32'(!e.err));
          if (!e.err) check("rx_data", 32'(dut.u_rx.rx_data), 32'(e.data));
          check("pwr_up_event_cycle", 32'(bus.pwr_up), 32'(e.pwr_before));
          @(negedge clk);
          check("pwr_up_after", 32'(bus.pwr_up), 32'(e.pwr_after));
          check("rx_err_pulse_width", 32'(bus.rx_err), 32'd0);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n        = 1'b0;
    bus.RX        = 1'b1;
    bus.rider_off = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwr_up", 32'(bus.pwr_up), 32'd0);
    check("reset_rx_err", 32'(bus.rx_err), 32'd0);
    rst_n = 1'b1;
    idle_line(1'b1, 20);

    // 1: unknown byte ignored, then 'g' powers up
    push(1'b0, 8'h41, 1'b0, 1'b0);
    send_byte(8'h41, 1'b1);
    push(1'b0, 8'h67, 1'b0, 1'b1);
    send_byte(8'h67, 1'b1);

    // 2: 's' with rider on -> PWR2, then rider_off drops power next clk
    push(1'b0, 8'h73, 1'b1, 1'b1);
    send_byte(8'h73, 1'b1);
    check("pwr2_held", 32'(bus.pwr_up), 32'd1);
    bus.rider_off = 1'b1;
    check("pwr2_before_edge", 32'(bus.pwr_up), 32'd1);
    @(negedge clk);
    check("rider_off_exit", 32'(bus.pwr_up), 32'd0);

    // 3: rider_off already high, 'g' then 's' -> straight to OFF
    push(1'b0, 8'h67, 1'b0, 1'b1);
    send_byte(8'h67, 1'b1);
    push(1'b0, 8'h73, 1'b1, 1'b0);
    send_byte(8'h73, 1'b1);

    // 4: reach PWR2, then 'g' collides with rising rider_off -> PWR1
    bus.rider_off = 1'b0;
    push(1'b0, 8'h67, 1'b0, 1'b1);
    send_byte(8'h67, 1'b1);
    push(1'b0, 8'h73, 1'b1, 1'b1);
    send_byte(8'h73, 1'b1);
    push(1'b0, 8'h67, 1'b1, 1'b1);
    fork
      send_byte(8'h67, 1'b1);
      begin
        wait_rdy(300);
        bus.rider_off = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    check("go_beats_rider_off", 32'(bus.pwr_up), 32'd1);
    push(1'b0, 8'h73, 1'b1, 1'b0);
    send_byte(8'h73, 1'b1);

    // 5: framing error, then a valid 'g'
    bus.rider_off = 1'b0;
    push(1'b1, 8'h00, 1'b0, 1'b0);
    send_byte(8'h67, 1'b0);
    push(1'b0, 8'h67, 1'b0, 1'b1);
    send_byte(8'h67, 1'b1);

    // 6: reset mid-frame in PWR1, line held low, ARM must wait for 16 high clks
    bus.RX = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame_pwr_up", 32'(bus.pwr_up), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_line(1'b0, 200);
    idle_line(1'b1, 10);
    idle_line(1'b0, 5);
    idle_line(1'b1, 15);
    idle_line(1'b0, 180);
    check("arm_blocks_frames", 32'(bus.pwr_up), 32'd0);
    idle_line(1'b1, 30);
    push(1'b0, 8'h67, 1'b0, 1'b1);
    send_byte(8'h67, 1'b1);

    repeat (50) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
